// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and its datapath.
// master = datapath side, slave = controller side.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       memread;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  modport master (
    output op, funct, zero, mem_ready,
    input  pcen, iord, memwrite, memread, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );

  modport slave (
    input  op, funct, zero, mem_ready,
    output pcen, iord, memwrite, memread, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle MIPS datapath: fetch/decode/execute/
// memory/writeback walk with a mem_ready stall handshake.
module multicycle_controller #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    AOP_NONE  = 2'd0,
    AOP_ADD   = 2'd1,
    AOP_SUB   = 2'd2,
    AOP_FUNCT = 2'd3
  } aluop_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e state_q, state_d;
  logic   is_sw_q, is_sw_d;

  logic       ready;
  logic       pcwrite, branch;
  logic       iord, memwrite, memread, irwrite, regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  aluop_e     aluop;

  assign ready = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    is_sw_d  = is_sw_q;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    memread  = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    illegal  = 1'b0;
    aluop    = AOP_NONE;
    unique case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        irwrite = ready;
        pcwrite = ready;
        alusrcb = 2'b01;
        aluop   = AOP_ADD;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        aluop   = AOP_ADD;
        // lw/sw choice is latched here so MEMADR never looks at op again
        is_sw_d = (bus.op == OP_SW);
        unique case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR, S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = AOP_ADD;
        if (state_q == S_ADDIEXEC) state_d = S_ADDIWB;
        else                       state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (ready) state_d = S_FETCH;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = AOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = AOP_SUB;
        branch  = 1'b1;
        pcsrc   = 2'b01;
        state_d = S_FETCH;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alucontrol = 3'b000;
    unique case (aluop)
      AOP_ADD: alucontrol = 3'b010;
      AOP_SUB: alucontrol = 3'b110;
      AOP_FUNCT: begin
        unique case (bus.funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b000;
    endcase
  end

  // Strobes are gated by reset so an asserted reset kills them mid-cycle,
  // before the state register has even been touched by a clock edge.
  assign bus.pcen       = reset & (pcwrite | (branch & bus.zero));
  assign bus.iord       = reset & iord;
  assign bus.memwrite   = reset & memwrite;
  assign bus.memread    = reset & memread;
  assign bus.irwrite    = reset & irwrite;
  assign bus.regdst     = reset & regdst;
  assign bus.memtoreg   = reset & memtoreg;
  assign bus.regwrite   = reset & regwrite;
  assign bus.alusrca    = reset & alusrca;
  assign bus.illegal    = reset & illegal;
  assign bus.alusrcb    = reset ? alusrcb : 2'b00;
  assign bus.pcsrc      = reset ? pcsrc : 2'b00;
  assign bus.alucontrol = reset ? alucontrol : 3'b000;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class and
// compares state plus the full strobe vector every cycle.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {pcen,iord,memwrite,memread,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,illegal}
  logic [16:0] outs;
  assign outs = {bus.pcen, bus.iord, bus.memwrite, bus.memread, bus.irwrite, bus.regdst,
                 bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc,
                 bus.alucontrol, bus.illegal};

  localparam logic [16:0] E_RST     = 17'd0;
  localparam logic [16:0] E_FETCH   = {9'b100110000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [16:0] E_FETCHW  = {9'b000100000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [16:0] E_DECODE  = {9'b000000000, 2'b11, 2'b00, 3'b010, 1'b0};
  localparam logic [16:0] E_DEC_ILL = {9'b000000000, 2'b11, 2'b00, 3'b010, 1'b1};
  localparam logic [16:0] E_MEMADR  = {9'b000000001, 2'b10, 2'b00, 3'b010, 1'b0};
  localparam logic [16:0] E_MEMRD   = {9'b010100000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] E_MEMWR   = {9'b011000000, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] E_MEMWB   = {9'b000000110, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] E_EXE_SUB = {9'b000000001, 2'b00, 2'b00, 3'b110, 1'b0};
  localparam logic [16:0] E_EXE_OR  = {9'b000000001, 2'b00, 2'b00, 3'b001, 1'b0};
  localparam logic [16:0] E_ALUWB   = {9'b000001010, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] E_BR_Z1   = {9'b100000001, 2'b00, 2'b01, 3'b110, 1'b0};
  localparam logic [16:0] E_BR_Z0   = {9'b000000001, 2'b00, 2'b01, 3'b110, 1'b0};
  localparam logic [16:0] E_ADDIWB  = {9'b000000010, 2'b00, 2'b00, 3'b000, 1'b0};
  localparam logic [16:0] E_JUMP    = {9'b100000000, 2'b00, 2'b10, 3'b000, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge: settle, check this cycle, advance one cycle.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] e);
    #1;
    chk({tag, ".st"}, 32'(bus.state), 32'(st));
    chk({tag, ".out"}, 32'(outs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.op = 6'b100011;
    bus.funct = 6'b000000;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;

    @(posedge clk);
    #1;
    chk("rst.st", 32'(bus.state), 32'd0);
    chk("rst.out", 32'(outs), 32'(E_RST));
    reset = 1'b1;

    // lw, no waits
    cyc("lw.f", 4'd0, E_FETCH);
    cyc("lw.d", 4'd1, E_DECODE);
    cyc("lw.a", 4'd2, E_MEMADR);
    cyc("lw.r", 4'd3, E_MEMRD);
    cyc("lw.wb", 4'd4, E_MEMWB);

    // R-type sub
    bus.op = 6'b000000; bus.funct = 6'b100010;
    cyc("sub.f", 4'd0, E_FETCH);
    cyc("sub.d", 4'd1, E_DECODE);
    cyc("sub.x", 4'd6, E_EXE_SUB);
    cyc("sub.wb", 4'd7, E_ALUWB);

    // R-type or
    bus.funct = 6'b100101;
    cyc("or.f", 4'd0, E_FETCH);
    cyc("or.d", 4'd1, E_DECODE);
    cyc("or.x", 4'd6, E_EXE_OR);
    cyc("or.wb", 4'd7, E_ALUWB);

    // beq taken then not taken
    bus.op = 6'b000100; bus.zero = 1'b1;
    cyc("beq1.f", 4'd0, E_FETCH);
    cyc("beq1.d", 4'd1, E_DECODE);
    cyc("beq1.b", 4'd8, E_BR_Z1);
    bus.zero = 1'b0;
    cyc("beq0.f", 4'd0, E_FETCH);
    cyc("beq0.d", 4'd1, E_DECODE);
    cyc("beq0.b", 4'd8, E_BR_Z0);

    // sw with three wait cycles in MEMWR
    bus.op = 6'b101011;
    cyc("sw.f", 4'd0, E_FETCH);
    cyc("sw.d", 4'd1, E_DECODE);
    cyc("sw.a", 4'd2, E_MEMADR);
    bus.mem_ready = 1'b0;
    cyc("sw.w0", 4'd5, E_MEMWR);
    cyc("sw.w1", 4'd5, E_MEMWR);
    cyc("sw.w2", 4'd5, E_MEMWR);
    bus.mem_ready = 1'b1;
    cyc("sw.w3", 4'd5, E_MEMWR);

    // illegal opcode, with one FETCH stall first
    bus.op = 6'b111111; bus.mem_ready = 1'b0;
    cyc("ill.fw", 4'd0, E_FETCHW);
    bus.mem_ready = 1'b1;
    cyc("ill.f", 4'd0, E_FETCH);
    cyc("ill.d", 4'd1, E_DEC_ILL);

    // addi
    bus.op = 6'b001000;
    cyc("addi.f", 4'd0, E_FETCH);
    cyc("addi.d", 4'd1, E_DECODE);
    bus.op = 6'b111111;  // op change outside DECODE must not matter
    cyc("addi.x", 4'd9, E_MEMADR);
    cyc("addi.wb", 4'd10, E_ADDIWB);

    // j
    bus.op = 6'b000010;
    cyc("j.f", 4'd0, E_FETCH);
    cyc("j.d", 4'd1, E_DECODE);
    cyc("j.j", 4'd11, E_JUMP);

    // lw with a MEMRD stall, reset mid-MEMWB
    bus.op = 6'b100011;
    cyc("lwr.f", 4'd0, E_FETCH);
    cyc("lwr.d", 4'd1, E_DECODE);
    cyc("lwr.a", 4'd2, E_MEMADR);
    bus.mem_ready = 1'b0;
    cyc("lwr.rw", 4'd3, E_MEMRD);
    bus.mem_ready = 1'b1;
    cyc("lwr.r", 4'd3, E_MEMRD);
    #1;
    chk("lwr.wb.st", 32'(bus.state), 32'd4);
    chk("lwr.wb.out", 32'(outs), 32'(E_MEMWB));
    #1;
    reset = 1'b0;
    #1;
    chk("arst.st", 32'(bus.state), 32'd0);
    chk("arst.regwrite", 32'(bus.regwrite), 32'd0);
    chk("arst.out", 32'(outs), 32'(E_RST));
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    cyc("post.fw", 4'd0, E_FETCHW);
    bus.mem_ready = 1'b1;
    cyc("post.f", 4'd0, E_FETCH);
    cyc("post.d", 4'd1, E_DECODE);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style sequencing FSM for the multicycle variant of the MIPS core.
- Drives a shared-memory datapath that has an instruction register, ALUOut, MDR, and A/B latches.
- Decodes opcode/funct, walks each instruction through its fetch/decode/execute/memory/writeback states, and generates every datapath strobe.
- Stalls on memory via a ready handshake.
- Sits beside the multicycle datapath inside the top-level core, replacing the single-cycle combinational controller.

Parameters:
- MEM_WAIT_EN, 1, when 1 the FETCH/MEMRD/MEMWR states hold until mem_ready=1; when 0 mem_ready is ignored (treated as 1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- op  input  6  instr[31:26] from the instruction register
- funct  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes access this cycle
- pcen  output  1  PC register enable = pcwrite | (branch & zero)
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- memwrite  output  1  memory write strobe
- memread  output  1  memory read request
- irwrite  output  1  instruction register load
- regdst  output  1  write register select: 1=rd, 0=rt
- memtoreg  output  1  writeback data select: 1=MDR, 0=ALUOut
- regwrite  output  1  register file write
- alusrca  output  1  ALU A select: 0=PC, 1=A
- alusrcb  output  2  ALU B select: 00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
- pcsrc  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- alucontrol  output  3  ALU operation
- illegal  output  1  one-cycle pulse on an undecodable opcode
- state  output  4  current state encoding, for debug

Behaviour:
- State encoding and reset:
  - Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
  - Encodings 12-15 go to FETCH on the next edge, with all strobes 0.
  - While reset=0: state=FETCH. All 1-bit outputs, alusrcb, pcsrc and alucontrol are forced to 0.
  - Reset mid-instruction aborts immediately. The first cycle after reset release is FETCH.
- Transitions:
  - FETCH -> DECODE when the access is ready, else hold.
  - DECODE -> lw/sw (100011/101011): MEMADR; R-type (000000): EXECUTE; beq (000100): BRANCH; addi (001000): ADDIEXEC; j (000010): JUMP.
  - DECODE -> any other opcode: FETCH, with illegal=1 for that DECODE cycle only.
  - MEMADR -> MEMRD (lw) or MEMWR (sw).
  - MEMRD -> MEMWB when ready, else hold.
  - MEMWR -> FETCH when ready, else hold.
  - MEMWB, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
  - EXECUTE -> ALUWB. ADDIEXEC -> ADDIWB.
- Outputs per state (unlisted outputs are 0):
  - FETCH: memread=1, irwrite=ready, alusrcb=01, aluop add, pcwrite=ready.
  - DECODE: alusrcb=11, aluop add.
  - MEMADR and ADDIEXEC: alusrca=1, alusrcb=10, aluop add.
  - MEMRD: memread=1, iord=1.
  - MEMWR: memwrite=1, iord=1. memwrite stays high every wait cycle.
  - MEMWB: regwrite=1, memtoreg=1.
  - EXECUTE: alusrca=1, aluop funct.
  - ALUWB: regwrite=1, regdst=1.
  - BRANCH: alusrca=1, aluop sub, branch=1, pcsrc=01.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- alucontrol decode:
  - aluop add -> 010; aluop sub -> 110.
  - aluop funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->010.
  - Outside EXECUTE/MEMADR/ADDIEXEC/FETCH/DECODE/BRANCH, alucontrol=000.
- pcen is combinational from state and zero. zero is sampled only in BRANCH.
- CPI: lw=5, sw=4, R-type=4, addi=4, beq=3, j=3, plus one cycle per mem_ready=0 cycle in FETCH/MEMRD/MEMWR.
- Edge cases:
  - mem_ready is ignored outside FETCH/MEMRD/MEMWR.
  - op/funct are sampled only in DECODE/EXECUTE. Changes elsewhere have no effect.

Test Plan:
1. Release reset with op=100011 and mem_ready=1 throughout -> state sequence 0,1,2,3,4,0. Exactly one cycle each of irwrite (cycle 0), memread (cycles 0 and 3), and regwrite+memtoreg (cycle 4).
2. R-type sub (op=000000, funct=100010) -> state sequence 0,1,6,7,0. alucontrol=110 in EXECUTE. regwrite=1 and regdst=1 in ALUWB.
3. beq with zero=1, then beq with zero=0 -> in BRANCH, pcen=1 and pcsrc=01 for the first, pcen=0 for the second. Each instruction takes 3 cycles.
4. sw with mem_ready held low 3 cycles in MEMWR -> memwrite high 4 consecutive cycles, then FETCH. No regwrite pulse at any point.
5. Opcode 111111 in DECODE -> illegal=1 for exactly one cycle, then FETCH. No regwrite/memwrite/pcen during the instruction except the FETCH pcen.
6. Assert reset low during MEMWB of a lw, asynchronously mid-cycle -> regwrite drops immediately. After release, state=0 and pcen=1 only when mem_ready=1.
